trigger_lut_multi: RTL and testbench

- Parametrised successor to the 4-stage, 32-channel SUMP trigger.
- Provides NUM_STAGES masked-compare stages over DATA_WIDTH channels.
- Each stage evaluates its compare through per-nibble 16-entry LUTs, which a shared loader FSM fills serially.
- Adds behaviour the previous trigger lacked:
  - per-stage delay counters
  - a saturating global level
  - a loader busy flag
  - fire-once-per-arm semantics
- Sits between the sampler and the capture controller; `run` starts capture.

---
 rtl/trigger_lut_multi.sv | 250 +++++++++++++++++++++++++
 tb/tb_trigger_lut_multi.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trigger_lut_multi.sv
// trigger_lut_multi: multi-stage masked-compare trigger.
// Each stage compares through per-nibble 16-entry LUTs. One shared loader FSM fills the LUTs.
// Stage fires are registered, so stage_match, level and run all update on the same edge.
// Optional serial channel mode is enabled by defining TRIGGER_SERIAL_EN.
module trigger_lut_multi #(
    parameter int unsigned NUM_STAGES = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LEVEL_BITS = 2,
    parameter int unsigned DELAY_BITS = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    input  logic [NUM_STAGES-1:0] wr_mask,
    input  logic [NUM_STAGES-1:0] wr_value,
    input  logic [NUM_STAGES-1:0] wr_config,
    input  logic [DATA_WIDTH-1:0] config_data,
    input  logic                  arm,
    output logic                  load_busy,
    output logic [LEVEL_BITS-1:0] level,
    output logic [NUM_STAGES-1:0] stage_match,
    output logic                  run
);
    localparam int unsigned NUM_NIBBLES = DATA_WIDTH / 4;

    typedef enum logic {LdIdle, LdLoad} ldState_t;
    typedef enum logic [1:0] {StIdle, StActive, StCount, StFired} stState_t;

    ldState_t              ldState, ldStateNext;
    logic [3:0]            ldCnt;
    logic [NUM_STAGES-1:0] enb;
    logic [DATA_WIDTH-1:0] maskReg, valueReg;
    logic [15:0]           lut [NUM_STAGES][NUM_NIBBLES];

    logic [DELAY_BITS-1:0] cfgDelay [NUM_STAGES];
    logic [LEVEL_BITS-1:0] cfgLevel [NUM_STAGES];
    logic [NUM_STAGES-1:0] cfgStart;

    logic [DATA_WIDTH-1:0] cmpData [NUM_STAGES];
    logic [NUM_STAGES-1:0] hitNow, hitReg, hitEff, fire;

    stState_t              stState [NUM_STAGES];
    stState_t              stStateNext [NUM_STAGES];
    logic [DELAY_BITS-1:0] delayCnt [NUM_STAGES];
    logic [DELAY_BITS-1:0] delayCntNext [NUM_STAGES];

`ifdef TRIGGER_SERIAL_EN
    logic [4:0]            cfgSerSel [NUM_STAGES];
    logic [NUM_STAGES-1:0] cfgSerEn;
    logic [DATA_WIDTH-1:0] shiftReg [NUM_STAGES];

    // Per-stage serial history of one selected channel (0..31), shifted on valid samples
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < NUM_STAGES; s++) shiftReg[s] <= '0;
        end else if (valid_in) begin
            for (int s = 0; s < NUM_STAGES; s++) begin
                shiftReg[s] <= {shiftReg[s][DATA_WIDTH-2:0], data_in[cfgSerSel[s]]};
            end
        end
    end
`endif

    // Loader state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) ldState <= LdIdle;
        else        ldState <= ldStateNext;
    end

    // Loader next state: a value write (re)starts a full 16-address sweep
    always_comb begin
        ldStateNext = ldState;
        unique case (ldState)
            LdIdle:  if (|wr_value) ldStateNext = LdLoad;
            LdLoad:  if (!(|wr_value) && ldCnt == 4'd15) ldStateNext = LdIdle;
            default: ldStateNext = LdIdle;
        endcase
    end

    // Loader outputs
    always_comb begin
        load_busy = (ldState == LdLoad);
    end

    // Loader datapath: shared mask/value, address counter, enabled-stage set
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ldCnt    <= '0;
            enb      <= '0;
            maskReg  <= '0;
            valueReg <= '0;
        end else begin
            if (|wr_mask) maskReg <= config_data;
            if (|wr_value) begin
                valueReg <= config_data;
                enb      <= enb | wr_value;
                ldCnt    <= '0;
            end else if (ldState == LdLoad) begin
                ldCnt <= ldCnt + 4'd1;
                if (ldCnt == 4'd15) enb <= '0;
            end
        end
    end

    // LUT fill: entry ldCnt of every nibble LUT of each enabled stage; contents survive reset
    always_ff @(posedge clock) begin
        if (load_busy) begin
            for (int s = 0; s < NUM_STAGES; s++) begin
                for (int n = 0; n < NUM_NIBBLES; n++) begin
                    if (enb[s]) begin
                        lut[s][n][ldCnt] <= ~|((ldCnt ^ valueReg[4*n +: 4]) & maskReg[4*n +: 4]);
                    end
                end
            end
        end
    end

    // Stage configuration registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cfgStart <= '0;
            for (int s = 0; s < NUM_STAGES; s++) begin
                cfgDelay[s] <= '0;
                cfgLevel[s] <= '0;
`ifdef TRIGGER_SERIAL_EN
                cfgSerSel[s] <= '0;
                cfgSerEn[s]  <= 1'b0;
`endif
            end
        end else begin
            for (int s = 0; s < NUM_STAGES; s++) begin
                if (wr_config[s]) begin
                    cfgDelay[s] <= config_data[DELAY_BITS-1:0];
                    cfgLevel[s] <= LEVEL_BITS'(config_data[17:16]);
                    cfgStart[s] <= config_data[27];
`ifdef TRIGGER_SERIAL_EN
                    cfgSerSel[s] <= config_data[24:20];
                    cfgSerEn[s]  <= config_data[26];
`endif
                end
            end
        end
    end

    // Compare: AND of all nibble-LUT lookups
    always_comb begin
        for (int s = 0; s < NUM_STAGES; s++) begin
`ifdef TRIGGER_SERIAL_EN
            cmpData[s] = cfgSerEn[s] ? shiftReg[s] : data_in;
`else
            cmpData[s] = data_in;
`endif
            hitNow[s] = 1'b1;
            for (int n = 0; n < NUM_NIBBLES; n++) begin
                hitNow[s] = hitNow[s] & lut[s][n][cmpData[s][4*n +: 4]];
            end
        end
        // A stage whose LUT is being rewritten must not trigger on half-loaded contents
        hitEff = hitReg & ~({NUM_STAGES{load_busy}} & enb);
    end

    // Registered hit, qualified by valid_in
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)        hitReg <= '0;
        else if (arm)      hitReg <= '0;
        else if (valid_in) hitReg <= hitNow;
        else               hitReg <= '0;
    end

    // Stage state and delay counter registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < NUM_STAGES; s++) begin
                stState[s]  <= StIdle;
                delayCnt[s] <= '0;
            end
        end else begin
            for (int s = 0; s < NUM_STAGES; s++) begin
                stState[s]  <= stStateNext[s];
                delayCnt[s] <= delayCntNext[s];
            end
        end
    end

    // Stage outputs: fire decision
    always_comb begin
        fire = '0;
        for (int s = 0; s < NUM_STAGES; s++) begin
            unique case (stState[s])
                StActive: fire[s] = hitEff[s] && (cfgLevel[s] <= level) && (cfgDelay[s] == '0);
                StCount:  fire[s] = valid_in && (delayCnt[s] <= DELAY_BITS'(1));
                default:  fire[s] = 1'b0;
            endcase
        end
        if (arm) fire = '0;
    end

    // Stage next state; arm overrides everything
    always_comb begin
        for (int s = 0; s < NUM_STAGES; s++) begin
            stStateNext[s]  = stState[s];
            delayCntNext[s] = delayCnt[s];
            unique case (stState[s])
                StIdle: if (cfgLevel[s] <= level) stStateNext[s] = StActive;
                StActive: begin
                    if (cfgLevel[s] > level) begin
                        stStateNext[s] = StIdle;
                    end else if (fire[s]) begin
                        stStateNext[s] = StFired;
                    end else if (hitEff[s]) begin
                        delayCntNext[s] = cfgDelay[s];
                        stStateNext[s]  = StCount;
                    end
                end
                StCount: begin
                    if (fire[s]) begin
                        stStateNext[s]  = StFired;
                        delayCntNext[s] = '0;
                    end else if (valid_in) begin
                        delayCntNext[s] = delayCnt[s] - DELAY_BITS'(1);
                    end
                end
                default: stStateNext[s] = stState[s];
            endcase
            if (arm) begin
                stStateNext[s]  = (cfgLevel[s] == '0) ? StActive : StIdle;
                delayCntNext[s] = '0;
            end
        end
    end

    // Fire pulse, saturating level and sticky run
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stage_match <= '0;
            level       <= '0;
            run         <= 1'b0;
        end else if (arm) begin
            stage_match <= '0;
            level       <= '0;
            run         <= 1'b0;
        end else begin
            stage_match <= fire;
            if (|fire && level != '1) level <= level + LEVEL_BITS'(1);
            if (|(fire & cfgStart)) run <= 1'b1;
        end
    end

endmodule

// File: tb/tb_trigger_lut_multi.sv
// Directed bench for trigger_lut_multi (default parameters).
module tb_trigger_lut_multi;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] data_in = '0;
    logic        valid_in = 1'b0;
    logic [3:0]  wr_mask = '0;
    logic [3:0]  wr_value = '0;
    logic [3:0]  wr_config = '0;
    logic [31:0] config_data = '0;
    logic        arm = 1'b0;
    logic        load_busy;
    logic [1:0]  level;
    logic [3:0]  stage_match;
    logic        run;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] mask;
        logic [31:0] value;
        logic [31:0] data;
        logic        expHit;
    } vec_t;

    vec_t vecs [10];

    trigger_lut_multi dut (
        .clock       (clock),
        .reset       (reset),
        .data_in     (data_in),
        .valid_in    (valid_in),
        .wr_mask     (wr_mask),
        .wr_value    (wr_value),
        .wr_config   (wr_config),
        .config_data (config_data),
        .arm         (arm),
        .load_busy   (load_busy),
        .level       (level),
        .stage_match (stage_match),
        .run         (run)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic writeMask(input logic [31:0] m);
        wr_mask = 4'b0001; config_data = m;
        cycle();
        wr_mask = '0;
    endtask

    task automatic writeValue(input logic [3:0] stages, input logic [31:0] v);
        wr_value = stages; config_data = v;
        cycle();
        wr_value = '0;
    endtask

    task automatic writeConfig(input logic [3:0] stages, input logic [31:0] c);
        wr_config = stages; config_data = c;
        cycle();
        wr_config = '0;
    endtask

    task automatic armPulse();
        arm = 1'b1;
        cycle();
        arm = 1'b0;
    endtask

    task automatic sample(input logic [31:0] d);
        data_in = d; valid_in = 1'b1;
        cycle();
        valid_in = 1'b0;
    endtask

    // Counts cycles with load_busy high; returns once idle or the budget runs out
    task automatic busyCycles(output int n);
        n = 0;
        while (load_busy && n < 64) begin
            n++;
            cycle();
        end
    endtask

    int n;

    initial begin
        vecs[0] = '{32'h0000_00FF, 32'h0000_00A5, 32'h1234_56A5, 1'b1};
        vecs[1] = '{32'h0000_00FF, 32'h0000_00A5, 32'h1234_56A4, 1'b0};
        vecs[2] = '{32'h0000_00FF, 32'h0000_00A5, 32'hFFFF_FFA5, 1'b1};
        vecs[3] = '{32'hF0F0_F0F0, 32'h1234_5678, 32'h1F3F_5F7F, 1'b1};
        vecs[4] = '{32'hF0F0_F0F0, 32'h1234_5678, 32'h2F3F_5F7F, 1'b0};
        vecs[5] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
        vecs[6] = '{32'hFFFF_FFFF, 32'hCAFE_BABE, 32'hCAFE_BABE, 1'b1};
        vecs[7] = '{32'hFFFF_FFFF, 32'hCAFE_BABE, 32'hCAFE_BABF, 1'b0};
        vecs[8] = '{32'h0000_000C, 32'h0000_0008, 32'h0000_000B, 1'b1};
        vecs[9] = '{32'h0000_000C, 32'h0000_0008, 32'h0000_0004, 1'b0};

        // Reset state
        cycle(); cycle();
        check("reset_busy", 32'(load_busy), 32'd0);
        check("reset_level", 32'(level), 32'd0);
        check("reset_match", 32'(stage_match), 32'd0);
        check("reset_run", 32'(run), 32'd0);
        reset = 1'b1;
        cycle();

        // Give every stage a defined LUT that the stimulus never hits
        writeMask(32'hFFFF_FFFF);
        writeValue(4'hF, 32'hDEAD_BEEF);
        busyCycles(n);
        check("init_busy_len", n, 16);

        // Basic load and fire
        writeConfig(4'b0001, 32'h0800_0000);
        writeMask(32'h0000_00FF);
        writeValue(4'b0001, 32'h0000_00A5);
        busyCycles(n);
        check("load_busy_len", n, 16);
        sample(32'h1234_56A4);
        cycle();
        check("load_nomatch", 32'(stage_match), 32'd0);
        sample(32'h1234_56A5);
        check("load_hit_latency", 32'(stage_match), 32'd0);
        cycle();
        check("load_match", 32'(stage_match), 32'h1);
        check("load_level", 32'(level), 32'd1);
        check("load_run", 32'(run), 32'd1);
        cycle();
        check("load_match_pulse", 32'(stage_match), 32'd0);
        check("load_level_hold", 32'(level), 32'd1);

        // Compare table
        for (int i = 0; i < 10; i++) begin
            writeMask(vecs[i].mask);
            writeValue(4'b0001, vecs[i].value);
            busyCycles(n);
            armPulse();
            sample(vecs[i].data);
            cycle();
            check($sformatf("vec%0d_match", i), 32'(stage_match[0]), 32'(vecs[i].expHit));
            check($sformatf("vec%0d_run", i), 32'(run), 32'(vecs[i].expHit));
        end

        // Delay of 3 valid samples, stretched by gaps
        writeConfig(4'b0001, 32'h0800_0003);
        writeMask(32'h0000_00FF);
        writeValue(4'b0001, 32'h0000_00A5);
        busyCycles(n);
        armPulse();
        sample(32'h0000_00A5);
        cycle();
        check("delay_no_early", 32'(stage_match), 32'd0);
        sample(32'h0);
        check("delay_after1", 32'(stage_match), 32'd0);
        cycle(); cycle();
        check("delay_gap", 32'(stage_match), 32'd0);
        sample(32'h0);
        check("delay_after2", 32'(stage_match), 32'd0);
        cycle(); cycle(); cycle();
        check("delay_gap2", 32'(stage_match), 32'd0);
        sample(32'h0);
        check("delay_fire", 32'(stage_match), 32'h1);
        check("delay_run", 32'(run), 32'd1);

        // Staged: stage1 needs level 1
        writeConfig(4'b0001, 32'h0000_0000);
        writeConfig(4'b0010, 32'h0801_0000);
        writeValue(4'b0001, 32'h0000_00A5);
        busyCycles(n);
        writeValue(4'b0010, 32'h0000_003C);
        busyCycles(n);
        armPulse();
        sample(32'h0000_003C);
        cycle();
        check("staged_early", 32'(stage_match), 32'd0);
        check("staged_early_lvl", 32'(level), 32'd0);
        sample(32'h0000_00A5);
        cycle();
        check("staged_s0", 32'(stage_match), 32'h1);
        check("staged_s0_run", 32'(run), 32'd0);
        sample(32'h0000_003C);
        cycle();
        check("staged_s1", 32'(stage_match), 32'h2);
        check("staged_run", 32'(run), 32'd1);
        check("staged_level", 32'(level), 32'd2);

        // Simultaneous fires add one level
        writeConfig(4'hF, 32'h0000_0000);
        writeValue(4'hF, 32'h0000_005A);
        busyCycles(n);
        armPulse();
        sample(32'h0000_005A);
        cycle();
        check("simul_match", 32'(stage_match), 32'hF);
        check("simul_level", 32'(level), 32'd1);

        // Chain of single fires saturates level at 3
        writeConfig(4'b0010, 32'h0001_0000);
        writeConfig(4'b0100, 32'h0002_0000);
        writeConfig(4'b1000, 32'h0003_0000);
        armPulse();
        for (int i = 0; i < 3; i++) begin
            sample(32'h0000_005A);
            cycle();
        end
        check("sat_level3", 32'(level), 32'd3);
        sample(32'h0000_005A);
        cycle();
        check("sat_s3", 32'(stage_match), 32'h8);
        check("sat_level_hold", 32'(level), 32'd3);

        // Load restart mid-sweep
        writeConfig(4'b0011, 32'h0000_0000);
        writeConfig(4'b1100, 32'h0003_0000);
        writeValue(4'b0001, 32'h0000_0011);
        for (int i = 0; i < 7; i++) cycle();
        check("restart_busy_mid", 32'(load_busy), 32'd1);
        writeValue(4'b0010, 32'h0000_0022);
        busyCycles(n);
        check("restart_busy_len", n, 16);
        armPulse();
        sample(32'h0000_0011);
        cycle();
        check("restart_old_val", 32'(stage_match), 32'd0);
        armPulse();
        sample(32'h0000_0022);
        cycle();
        check("restart_new_val", 32'(stage_match), 32'h3);

        // Arm clears run/level and allows refire
        writeConfig(4'b0001, 32'h0800_0000);
        armPulse();
        sample(32'h0000_0022);
        cycle();
        check("arm_pre_run", 32'(run), 32'd1);
        armPulse();
        check("arm_run", 32'(run), 32'd0);
        check("arm_level", 32'(level), 32'd0);
        sample(32'h0000_0022);
        cycle();
        check("arm_refire", 32'(stage_match[0]), 32'd1);
        check("arm_refire_run", 32'(run), 32'd1);

        // Asynchronous reset mid-load
        writeValue(4'b0001, 32'h0000_0033);
        cycle(); cycle();
        check("rst_busy_before", 32'(load_busy), 32'd1);
        reset = 1'b0;
        #1;
        check("rst_busy", 32'(load_busy), 32'd0);
        check("rst_run", 32'(run), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        cycle();
        reset = 1'b1;
        cycle();
        check("rst_busy_after", 32'(load_busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
